// File: rtl/mem_if_pkg.sv
// Shared types and default geometry for the main-memory responder.
package mem_if_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

  localparam int BEAT_BYTES = 8;
  localparam int BEAT_IDX_W = $clog2(8);
  localparam int MEM_AW     = $clog2(4096);

endpackage

// File: rtl/main_memory_array.sv
// Single-port beat storage: one-cycle registered read, synchronous write, no reset.
module main_memory_array #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4096,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_reg;

  // Read data only moves on an enabled read, so it holds between beats.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem_reg[addr] <= wdata;
      end else begin
        rdata_reg <= mem_reg[addr];
      end
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/main_memory_responder.sv
// Main-memory target for L2 line fills/write-backs: toggle-detected requests,
// fixed-latency bursts of 64-bit beats marked by stb toggles.
module main_memory_responder
  import mem_if_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 64,
  parameter int BURST_LENGTH   = 8,
  parameter int MEM_DEPTH      = 4096,
  parameter int ACCESS_LATENCY = 4,
  parameter int STB_PERIOD     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  addrstb_MEM,
  input  logic                  we_MEM,
  input  logic [ADDR_WIDTH-1:0] addr_MEM,
  inout  wire  [DATA_WIDTH-1:0] data_MEM,
  output logic                  stb,
  output logic                  busy
);

  localparam int BIDX_W     = $clog2(BURST_LENGTH);
  localparam int ARR_AW     = $clog2(MEM_DEPTH);
  localparam int ADDR_SHIFT = $clog2(BEAT_BYTES);
  localparam int LAT_W      = (ACCESS_LATENCY > 1) ? $clog2(ACCESS_LATENCY) : 1;
  localparam int GAP_W      = (STB_PERIOD > 1) ? $clog2(STB_PERIOD) : 1;

  localparam logic [LAT_W-1:0]  LAT_LOAD   = LAT_W'(ACCESS_LATENCY - 1);
  localparam logic [GAP_W-1:0]  GAP_LOAD   = GAP_W'(STB_PERIOD - 1);
  localparam logic [BIDX_W-1:0] LAST_BEAT  = BIDX_W'(BURST_LENGTH - 1);
  localparam logic [ARR_AW-1:0] ALIGN_MASK = ~ARR_AW'(BURST_LENGTH - 1);

  state_t              state_reg, state_next;
  logic                addrstb_q_reg, armed_reg, we_reg, stb_reg;
  logic [ARR_AW-1:0]   base_reg;
  logic [LAT_W-1:0]    lat_cnt_reg;
  logic [GAP_W-1:0]    gap_cnt_reg;
  logic [BIDX_W-1:0]   beat_cnt_reg;
  logic                toggle, accept, beat_fire, burst_done;
  logic [BIDX_W-1:0]   beat_idx;
  logic [ARR_AW-1:0]   arr_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                addr_unused;

  // Byte offset within a beat and address bits above the array are don't-care.
  assign addr_unused = ^{addr_MEM[ADDR_WIDTH-1:ADDR_SHIFT+ARR_AW], addr_MEM[ADDR_SHIFT-1:0]};

  assign toggle = armed_reg && (addrstb_MEM != addrstb_q_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (toggle) state_next = WAIT;
      WAIT:    if (lat_cnt_reg == '0) state_next = BURST;
      BURST:   if (burst_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // beat_idx is the beat that fires on the coming edge; the array is accessed on that same edge.
  always_comb begin
    accept     = 1'b0;
    beat_fire  = 1'b0;
    burst_done = 1'b0;
    beat_idx   = '0;
    case (state_reg)
      IDLE: accept = toggle;
      WAIT: beat_fire = (lat_cnt_reg == '0);
      BURST: begin
        if (gap_cnt_reg == '0) begin
          if (beat_cnt_reg == LAST_BEAT) begin
            burst_done = 1'b1;
          end else begin
            beat_fire = 1'b1;
            beat_idx  = beat_cnt_reg + BIDX_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addrstb_q_reg <= 1'b0;
      armed_reg     <= 1'b0;
      we_reg        <= 1'b0;
      stb_reg       <= 1'b0;
      base_reg      <= '0;
      lat_cnt_reg   <= '0;
      gap_cnt_reg   <= '0;
      beat_cnt_reg  <= '0;
    end else begin
      addrstb_q_reg <= addrstb_MEM;
      armed_reg     <= 1'b1;
      if (accept) begin
        we_reg      <= we_MEM;
        base_reg    <= addr_MEM[ADDR_SHIFT +: ARR_AW] & ALIGN_MASK;
        lat_cnt_reg <= LAT_LOAD;
      end else if (state_reg == WAIT && lat_cnt_reg != '0) begin
        lat_cnt_reg <= lat_cnt_reg - LAT_W'(1);
      end
      if (beat_fire) begin
        stb_reg      <= ~stb_reg;
        beat_cnt_reg <= beat_idx;
        gap_cnt_reg  <= GAP_LOAD;
      end else if (state_reg == BURST && gap_cnt_reg != '0) begin
        gap_cnt_reg <= gap_cnt_reg - GAP_W'(1);
      end
    end
  end

  // Base is burst-aligned, so OR-ing in the beat index never carries.
  assign arr_addr = base_reg | ARR_AW'(beat_idx);

  main_memory_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (MEM_DEPTH),
    .AW        (ARR_AW)
  ) u_array (
    .clk  (clk),
    .en   (beat_fire),
    .we   (~we_reg),
    .addr (arr_addr),
    .wdata(data_MEM),
    .rdata(rd_data)
  );

  assign stb      = stb_reg;
  assign busy     = (state_reg != IDLE);
  assign data_MEM = (state_reg == BURST && we_reg) ? rd_data : 'z;

endmodule
